sr_cmd_sequencer: RTL and testbench

//  Upstream driver for the SR NAND latch stage. Takes two raw, bouncy, asynchronous

---
 rtl/sr_cmd_sequencer.sv | 124 ++++++++++++
 tb/tb_sr_cmd_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_sequencer.sv
// Front end for an SR NAND latch. It synchronises, debounces and edge-detects two raw buttons,
// then sequences the requests into s/r pulses that are never active at the same time.
module sr_cmd_sequencer #(
  parameter int unsigned DB_CYCLES      = 4,
  parameter int unsigned PULSE_LEN      = 3,
  parameter int unsigned GAP_LEN        = 2,
  parameter bit          OUT_ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic set_btn,
  input  logic reset_btn,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);

  localparam int unsigned CW   = $clog2(DB_CYCLES + 1);
  localparam int unsigned TMAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic        ACT  = OUT_ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic        INACT = ~ACT;

  typedef enum logic [1:0] {IDLE, DRIVE_S, DRIVE_R, GAP} state_e;

  // Bit 0 carries the set request, bit 1 the reset request.
  logic [1:0]    sync1_q, sync2_q, lvl_q, lvl_prev_q, rise;
  logic [1:0]    pend_q, pend_d;
  logic [CW-1:0] cnt_q [2];
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          conflict_d, arb;

  // Synchroniser, debouncer and the delayed level used for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= {reset_btn, set_btn};
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != lvl_q[i]) begin
          if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
            lvl_q[i] <= ~lvl_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CW'(1);
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign rise = lvl_q & ~lvl_prev_q;

  // The last GAP cycle arbitrates like IDLE, so back-to-back requests see exactly GAP_LEN idle cycles
  assign arb = (state_q == IDLE) || ((state_q == GAP) && (timer_q == TW'(GAP_LEN - 1)));

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    pend_d     = pend_q | rise;
    conflict_d = 1'b0;
    case (state_q)
      IDLE: ;
      DRIVE_S, DRIVE_R: begin
        if (timer_q == TW'(PULSE_LEN - 1)) begin
          state_d = GAP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      GAP: begin
        if (timer_q == TW'(GAP_LEN - 1)) state_d = IDLE;
        else                             timer_d = timer_q + TW'(1);
      end
    endcase
    if (arb) begin
      if (&pend_q) begin
        conflict_d = 1'b1;
        pend_d     = rise;
      end else if (pend_q[0]) begin
        state_d   = DRIVE_S;
        timer_d   = '0;
        pend_d[0] = rise[0];
      end else if (pend_q[1]) begin
        state_d   = DRIVE_R;
        timer_d   = '0;
        pend_d[1] = rise[1];
      end
    end
  end

  // Outputs are registered from the next state, so they line up with state_q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      pend_q   <= '0;
      s        <= INACT;
      r        <= INACT;
      busy     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      pend_q   <= pend_d;
      s        <= (state_d == DRIVE_S) ? ACT : INACT;
      r        <= (state_d == DRIVE_R) ? ACT : INACT;
      busy     <= (state_d != IDLE);
      conflict <= conflict_d;
    end
  end

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Bench for sr_cmd_sequencer: an active-high and an active-low instance share stimulus and are
// compared every cycle against a queue-based behavioural model, plus literal per-scenario counts.
module tb_sr_cmd_sequencer;

  localparam int unsigned DB    = 4;
  localparam int unsigned PLEN  = 3;
  localparam int unsigned GLEN  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set_btn = 1'b0;
  logic reset_btn = 1'b0;
  logic s_h, r_h, busy_h, conf_h;
  logic s_l, r_l, busy_l, conf_l;

  always #5 clk = ~clk;

  sr_cmd_sequencer #(.DB_CYCLES(DB), .PULSE_LEN(PLEN), .GAP_LEN(GLEN), .OUT_ACTIVE_LOW(1'b0)) u_dut_h (
    .clk(clk), .rst(rst), .set_btn(set_btn), .reset_btn(reset_btn),
    .s(s_h), .r(r_h), .busy(busy_h), .conflict(conf_h));

  sr_cmd_sequencer #(.DB_CYCLES(DB), .PULSE_LEN(PLEN), .GAP_LEN(GLEN), .OUT_ACTIVE_LOW(1'b1)) u_dut_l (
    .clk(clk), .rst(rst), .set_btn(set_btn), .reset_btn(reset_btn),
    .s(s_l), .r(r_l), .busy(busy_l), .conflict(conf_l));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: output schedule as a queue of future cycles (0 idle, 1 s, 2 r, 3 gap)
  bit [1:0] m_sy1, m_sy2, m_lvl, m_prev, m_pend;
  int       m_run [2];
  int       m_sched [$];
  bit       m_s, m_r, m_busy, m_conf;

  task automatic model_step();
    bit [1:0] raw, rise, op;
    int cur;
    if (rst) begin
      m_sy1 = '0; m_sy2 = '0; m_lvl = '0; m_prev = '0; m_pend = '0;
      m_run[0] = 0; m_run[1] = 0;
      m_sched.delete();
      m_s = 0; m_r = 0; m_busy = 0; m_conf = 0;
    end else begin
      raw  = {reset_btn, set_btn};
      rise = m_lvl & ~m_prev;
      op   = m_pend;
      m_conf = 0;
      if (m_sched.size() == 0) begin
        if (op == 2'b11) begin
          m_conf = 1; op = 2'b00;
        end else if (op[0] || op[1]) begin
          for (int i = 0; i < int'(PLEN); i++) m_sched.push_back(op[0] ? 1 : 2);
          for (int i = 0; i < int'(GLEN); i++) m_sched.push_back(3);
          if (op[0]) op[0] = 1'b0; else op[1] = 1'b0;
        end
      end
      m_pend = op | rise;
      cur    = (m_sched.size() != 0) ? m_sched.pop_front() : 0;
      m_s    = (cur == 1);
      m_r    = (cur == 2);
      m_busy = (cur != 0);
      m_prev = m_lvl;
      for (int i = 0; i < 2; i++) begin
        if (m_sy2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == int'(DB)) begin
            m_lvl[i] = ~m_lvl[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_sy2 = m_sy1;
      m_sy1 = raw;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Per-scenario statistics taken from the active-high instance
  int  s_cnt, r_cnt, busy_cnt, conf_cnt, s_pulses, r_pulses, sl_low, rl_low;
  int  first_s, last_s, first_r;
  bit  prev_s, prev_r;

  task automatic clr_stats();
    s_cnt = 0; r_cnt = 0; busy_cnt = 0; conf_cnt = 0; s_pulses = 0; r_pulses = 0;
    sl_low = 0; rl_low = 0; first_s = -1; last_s = -1; first_r = -1;
  endtask

  task automatic compare_step();
    chk("s_h",  int'(s_h),  int'(m_s));
    chk("r_h",  int'(r_h),  int'(m_r));
    chk("busy_h", int'(busy_h), int'(m_busy));
    chk("conflict_h", int'(conf_h), int'(m_conf));
    chk("s_l",  int'(s_l),  int'(!m_s));
    chk("r_l",  int'(r_l),  int'(!m_r));
    chk("busy_l", int'(busy_l), int'(m_busy));
    chk("conflict_l", int'(conf_l), int'(m_conf));
    chk("no_overlap", int'(s_h && r_h), 0);
    if (s_h) begin
      s_cnt++; last_s = cyc;
      if (first_s < 0) first_s = cyc;
      if (!prev_s) s_pulses++;
    end
    if (r_h) begin
      r_cnt++;
      if (first_r < 0) first_r = cyc;
      if (!prev_r) r_pulses++;
    end
    if (busy_h) busy_cnt++;
    if (conf_h) conf_cnt++;
    if (!s_l) sl_low++;
    if (!r_l) rl_low++;
    prev_s = s_h;
    prev_r = r_h;
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) compare_step();
  end

  // Inputs change 2 time units after the falling edge, clear of both sampling points
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #2;
    end
  endtask

  int start;

  initial begin
    clr_stats();
    tick(3);
    chk("rst_s_h", int'(s_h), 0);
    chk("rst_r_h", int'(r_h), 0);
    chk("rst_busy", int'(busy_h), 0);
    chk("rst_conflict", int'(conf_h), 0);
    chk("rst_s_l", int'(s_l), 1);
    chk("rst_r_l", int'(r_l), 1);
    rst = 1'b0;
    chk_en = 1'b1;
    tick(3);

    // Clean set press: s after edge start+8 (7 cycles after the first sampling edge)
    clr_stats(); start = cyc;
    set_btn = 1'b1; tick(20);
    set_btn = 1'b0; tick(12);
    chk("s1_s_cycles", s_cnt, 3);
    chk("s1_s_latency", first_s - start, 8);
    chk("s1_busy_cycles", busy_cnt, 5);
    chk("s1_r_cycles", r_cnt, 0);
    chk("s1_al_s_low", sl_low, 3);
    chk("s1_al_r_low", rl_low, 0);

    // Bouncing press gives one pulse
    clr_stats();
    set_btn = 1'b1; tick(1); set_btn = 1'b0; tick(1);
    set_btn = 1'b1; tick(1); set_btn = 1'b0; tick(1);
    set_btn = 1'b1; tick(20);
    set_btn = 1'b0; tick(12);
    chk("s2_pulses", s_pulses, 1);
    chk("s2_s_cycles", s_cnt, 3);

    // A 3-sample glitch is shorter than the debounce window
    clr_stats();
    set_btn = 1'b1; tick(3);
    set_btn = 1'b0; tick(15);
    chk("s2_glitch_pulses", s_pulses, 0);
    chk("s2_glitch_busy", busy_cnt, 0);

    // Simultaneous requests are dropped with a conflict pulse
    clr_stats();
    set_btn = 1'b1; reset_btn = 1'b1; tick(20);
    set_btn = 1'b0; reset_btn = 1'b0; tick(12);
    chk("s3_conflict", conf_cnt, 1);
    chk("s3_s_cycles", s_cnt, 0);
    chk("s3_r_cycles", r_cnt, 0);
    chk("s3_busy", busy_cnt, 0);

    // Reset request becomes pending during the s pulse and follows after the gap
    clr_stats();
    set_btn = 1'b1; tick(3);
    reset_btn = 1'b1; tick(25);
    set_btn = 1'b0; reset_btn = 1'b0; tick(12);
    chk("s4_s_cycles", s_cnt, 3);
    chk("s4_r_cycles", r_cnt, 3);
    chk("s4_gap", first_r - last_s, 3);
    chk("s4_busy", busy_cnt, 10);
    chk("s4_r_pulses", r_pulses, 1);

    // Reset in the second DRIVE_S cycle
    clr_stats(); start = cyc;
    set_btn = 1'b1; tick(9);
    chk("s5_s_before", int'(s_h), 1);
    rst = 1'b1; set_btn = 1'b0;
    #1;
    chk("s5_s_now", int'(s_h), 0);
    chk("s5_busy_now", int'(busy_h), 0);
    chk("s5_conf_now", int'(conf_h), 0);
    chk("s5_s_l_now", int'(s_l), 1);
    tick(2);
    rst = 1'b0;
    clr_stats();
    tick(20);
    chk("s5_after_pulses", s_pulses + r_pulses, 0);
    chk("s5_after_busy", busy_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
